// File: rtl/flags_stack_unit_pkg.sv
// Shared CPU definitions: architectural flag bit positions.
package cpu_pkg;
  localparam int FLAG_ZF        = 0;
  localparam int FLAG_NF        = 1;
  localparam int FLAG_OF        = 2;
  localparam int FLAG_CF        = 3;
  localparam int FLAG_MIN_WIDTH = 4;
endpackage

// File: rtl/flags_stack_unit_if.sv
// Bus between the ALU/control side (master) and the flag unit (slave).
interface flags_stack_unit_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] FLAGS_IN;
  logic             FWE;
  logic [WIDTH-1:0] FMASK;
  logic             PUSH;
  logic             POP;
  logic             ERR_CLR;
  logic [WIDTH-1:0] FLAGS_OUT;
  logic             ZF, NF, OF, CF;
  logic [CW-1:0]    STK_CNT;
  logic             STK_FULL;
  logic             STK_EMPTY;
  logic             STK_ERR;

  modport master (
    output FLAGS_IN, FWE, FMASK, PUSH, POP, ERR_CLR,
    input  FLAGS_OUT, ZF, NF, OF, CF, STK_CNT, STK_FULL, STK_EMPTY, STK_ERR
  );

  modport slave (
    input  FLAGS_IN, FWE, FMASK, PUSH, POP, ERR_CLR,
    output FLAGS_OUT, ZF, NF, OF, CF, STK_CNT, STK_FULL, STK_EMPTY, STK_ERR
  );
endinterface

// File: rtl/flags_stack_unit_lifo.sv
// Save stack for flag snapshots: storage, occupancy count, error pulse.
// Callers must not assert push and pop together; the top resolves that case.
module flag_stack_lifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   cnt,
  output logic                         full,
  output logic                         empty,
  output logic                         err
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    rd_cnt;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic             do_push, do_pop;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign err     = (push & full) | (pop & empty);
  assign rd_cnt  = cnt_q - CW'(1);
  assign wr_idx  = cnt_q[AW-1:0];
  assign rd_idx  = rd_cnt[AW-1:0];
  assign dout    = mem_q[rd_idx];
  assign cnt     = cnt_q;

  // Occupancy: saturating up/down count, never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (do_push)     cnt_d = cnt_q + CW'(1);
    else if (do_pop) cnt_d = rd_cnt;
  end

  // Count register; stack contents are don't-care after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Storage write at the current top-of-stack slot.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_idx] <= din;
  end
endmodule

// File: rtl/flags_stack_unit.sv
// Live CPU status-flag register with masked update and interrupt save/restore.
module flags_stack_unit
  import cpu_pkg::*;
#(
  parameter int              WIDTH     = 4,
  parameter int              DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic               CLK,
  input logic               RESET,
  flags_stack_unit_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] flags_q, flags_d;
  logic             err_q, err_d;
  logic             push_req, pop_req;
  logic [WIDTH-1:0] top_val;
  logic [CW-1:0]    cnt;
  logic             full, empty, err_pulse;
  logic             do_restore;

  // Simultaneous push and pop cancel out: stack untouched, no error.
  assign push_req   = bus.PUSH & ~bus.POP;
  assign pop_req    = bus.POP & ~bus.PUSH;
  assign do_restore = pop_req & ~empty;

  flag_stack_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (push_req),
    .pop   (pop_req),
    .din   (flags_q),
    .dout  (top_val),
    .cnt   (cnt),
    .full  (full),
    .empty (empty),
    .err   (err_pulse)
  );

  // Live flags: a successful restore wins over the ALU write; otherwise masked merge.
  always_comb begin
    flags_d = flags_q;
    if (do_restore)   flags_d = top_val;
    else if (bus.FWE) flags_d = (flags_q & ~bus.FMASK) | (bus.FLAGS_IN & bus.FMASK);
  end

  // Sticky stack error: a new error beats a same-cycle clear.
  always_comb begin
    err_d = err_q;
    if (err_pulse)        err_d = 1'b1;
    else if (bus.ERR_CLR) err_d = 1'b0;
  end

  // State registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      flags_q <= RESET_VAL;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign bus.FLAGS_OUT = flags_q;
  assign bus.ZF        = flags_q[FLAG_ZF];
  assign bus.NF        = flags_q[FLAG_NF];
  assign bus.OF        = flags_q[FLAG_OF];
  assign bus.CF        = flags_q[FLAG_CF];
  assign bus.STK_CNT   = cnt;
  assign bus.STK_FULL  = full;
  assign bus.STK_EMPTY = empty;
  assign bus.STK_ERR   = err_q;
endmodule

// File: tb/tb_flags_stack_unit.sv
// Scoreboard bench for flags_stack_unit: a behavioural model predicts the state
// after every driven cycle; predictions are checked on the following falling edge.
module tb_flags_stack_unit;
  localparam int W  = 4;
  localparam int D  = 4;

  typedef struct {
    logic [W-1:0] flags;
    int           cnt;
    logic         err;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   failures = 0;

  exp_t         exp_q[$];
  exp_t         sb_e;
  logic [W-1:0] m_stk[$];
  logic [W-1:0] m_flags;
  logic         m_err;

  always #5 CLK = ~CLK;

  flags_stack_unit_if #(.WIDTH(W), .DEPTH(D)) bus ();

  flags_stack_unit #(.WIDTH(W), .DEPTH(D), .RESET_VAL('0)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: outputs are stable away from the rising edge.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      sb_e = exp_q.pop_front();
      chk("sb_flags", 32'(bus.FLAGS_OUT), 32'(sb_e.flags));
      chk("sb_cnt",   32'(bus.STK_CNT),   32'(sb_e.cnt));
      chk("sb_full",  32'(bus.STK_FULL),  32'(sb_e.cnt == D));
      chk("sb_empty", 32'(bus.STK_EMPTY), 32'(sb_e.cnt == 0));
      chk("sb_err",   32'(bus.STK_ERR),   32'(sb_e.err));
      chk("sb_taps",  32'({bus.CF, bus.OF, bus.NF, bus.ZF}), 32'(sb_e.flags[3:0]));
    end
  end

  task automatic idle_inputs();
    bus.FLAGS_IN = '0; bus.FWE = 1'b0; bus.FMASK = '0;
    bus.PUSH = 1'b0; bus.POP = 1'b0; bus.ERR_CLR = 1'b0;
  endtask

  task automatic model_reset();
    m_flags = '0;
    m_err   = 1'b0;
    m_stk.delete();
  endtask

  // One clock of stimulus; the model is advanced and its prediction queued.
  task automatic step(input logic [W-1:0] fin, input logic fwe, input logic [W-1:0] fm,
                      input logic push, input logic pop, input logic clr);
    logic [W-1:0] nf;
    logic         eset;
    exp_t         e;
    @(negedge CLK);
    bus.FLAGS_IN = fin; bus.FWE = fwe; bus.FMASK = fm;
    bus.PUSH = push; bus.POP = pop; bus.ERR_CLR = clr;
    @(posedge CLK);
    eset = 1'b0;
    nf   = fwe ? ((m_flags & ~fm) | (fin & fm)) : m_flags;
    if (push && !pop) begin
      if (m_stk.size() == D) eset = 1'b1;
      else m_stk.push_back(m_flags);
    end
    if (pop && !push) begin
      if (m_stk.size() == 0) eset = 1'b1;
      else nf = m_stk.pop_back();
    end
    m_flags = nf;
    m_err   = eset ? 1'b1 : (clr ? 1'b0 : m_err);
    e.flags = m_flags; e.cnt = m_stk.size(); e.err = m_err;
    exp_q.push_back(e);
    #1 idle_inputs();
  endtask

  task automatic set_flags(input logic [W-1:0] v);
    step(v, 1'b1, '1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    RESET = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge CLK);
    #2;
    chk("rst_flags", 32'(bus.FLAGS_OUT), 32'h0);
    chk("rst_cnt",   32'(bus.STK_CNT),   32'h0);
    chk("rst_empty", 32'(bus.STK_EMPTY), 32'h1);
    chk("rst_full",  32'(bus.STK_FULL),  32'h0);
    chk("rst_err",   32'(bus.STK_ERR),   32'h0);
    @(negedge CLK) RESET = 1'b0;

    // Masked write
    step(4'b1111, 1'b1, 4'b0101, 1'b0, 1'b0, 1'b0);
    #1;
    chk("mask_flags", 32'(bus.FLAGS_OUT), 32'h5);
    chk("mask_taps",  32'({bus.CF, bus.OF, bus.NF, bus.ZF}), 32'b0101);

    // Nesting
    set_flags(4'h3);
    step('0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    set_flags(4'h8);
    step('0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    set_flags(4'h1);
    step('0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    #1 chk("nest_pop1", 32'(bus.FLAGS_OUT), 32'h8);
    step('0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("nest_pop2",  32'(bus.FLAGS_OUT), 32'h3);
    chk("nest_empty", 32'(bus.STK_EMPTY), 32'h1);

    // Push with flag write in the same cycle
    set_flags(4'h2);
    step(4'h9, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
    #1 chk("pushfwe_live", 32'(bus.FLAGS_OUT), 32'h9);
    step('0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    #1 chk("pushfwe_pop", 32'(bus.FLAGS_OUT), 32'h2);

    // Overflow, error clear, underflow
    for (int i = 0; i < 5; i++) begin
      set_flags(W'(4'hA + i));
      step('0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    #1;
    chk("ovf_cnt",  32'(bus.STK_CNT),  32'h4);
    chk("ovf_full", 32'(bus.STK_FULL), 32'h1);
    chk("ovf_err",  32'(bus.STK_ERR),  32'h1);
    step('0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    #1 chk("errclr", 32'(bus.STK_ERR), 32'h0);
    step('0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    #1 chk("ovf_top", 32'(bus.FLAGS_OUT), 32'hD);
    repeat (3) step('0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    step('0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("unf_flags", 32'(bus.FLAGS_OUT), 32'hA);
    chk("unf_err",   32'(bus.STK_ERR),   32'h1);

    // Pop overrides flag write; push+pop is a stack no-op
    step('0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    set_flags(4'h4);
    step('0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    set_flags(4'h7);
    step(4'hA, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0);
    #1 chk("popfwe", 32'(bus.FLAGS_OUT), 32'h4);
    set_flags(4'h5);
    step('0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(4'h3, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0);
    #1;
    chk("pp_cnt",   32'(bus.STK_CNT),   32'h1);
    chk("pp_err",   32'(bus.STK_ERR),   32'h0);
    chk("pp_flags", 32'(bus.FLAGS_OUT), 32'h3);
    step('0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    #1 chk("pp_pop", 32'(bus.FLAGS_OUT), 32'h5);

    // Randomised traffic against the model
    for (int i = 0; i < 300; i++) begin
      step(W'($urandom), 1'($urandom), W'($urandom),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) == 0));
    end

    // Mid-run asynchronous reset with two entries stored and error set
    while (m_stk.size() > 0) step('0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    step('0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    set_flags(4'h6);
    step('0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step('0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    #1 chk("pre_rst_cnt", 32'(bus.STK_CNT), 32'h2);
    @(negedge CLK);
    #2 RESET = 1'b1;
    model_reset();
    #1;
    chk("arst_flags", 32'(bus.FLAGS_OUT), 32'h0);
    chk("arst_cnt",   32'(bus.STK_CNT),   32'h0);
    chk("arst_empty", 32'(bus.STK_EMPTY), 32'h1);
    chk("arst_err",   32'(bus.STK_ERR),   32'h0);
    @(negedge CLK) RESET = 1'b0;
    set_flags(4'hC);
    step('0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    @(negedge CLK);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
